// File: rtl/ga_pkg.sv
// ga_pkg: shared Johnson codes, phase indices and phase masks for the gate array sequencer
package ga_pkg;

    typedef logic [3:0] t_idx_t;

    localparam logic [7:0] JC [16] = '{
        8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F,
        8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80
    };

    localparam t_idx_t T_VLD0      = 4'd3;
    localparam t_idx_t T_VLD1      = 4'd7;
    localparam int     T_CPU_START = 8;

    // Circular window of len states starting at t0, wrapping modulo 16
    function automatic logic [15:0] win_mask(input int t0, input int len);
        logic [15:0] m;
        m = '0;
        for (int i = 0; i < 16; i++)
            if (i < len) m[4'((t0 + i) % 16)] = 1'b1;
        return m;
    endfunction

    localparam logic [15:0] PHI_N_MASK = 16'h3333;
    localparam logic [15:0] RAS_N_MASK = 16'h1111;
    localparam logic [15:0] CPU_N_MASK = win_mask(0, T_CPU_START);

endpackage

// File: rtl/ga_johnson_ring.sv
// ga_johnson_ring: 8-bit Johnson ring with legality check, self-correction and index counter
module ga_johnson_ring
    import ga_pkg::*;
(
    input  logic   CLK_n,
    input  logic   RESET,
    output logic   [7:0] s,
    output t_idx_t t,
    output t_idx_t t_nxt,
    output logic   seq_err
);

    logic [6:0] diff;
    logic       legal;
    logic [7:0] s_nxt;

    // A legal Johnson code has at most one boundary between adjacent bits
    always_comb begin
        diff  = s[6:0] ^ s[7:1];
        legal = (diff & (diff - 7'd1)) == 7'd0;
        s_nxt = legal ? {s[6:0], ~s[7]} : JC[0];
        t_nxt = legal ? t + 4'd1 : 4'd0;
    end

    // Ring, index and one-clock correction flag
    always_ff @(posedge CLK_n or posedge RESET)
        if (RESET) begin
            s       <= JC[0];
            t       <= '0;
            seq_err <= 1'b0;
        end else begin
            s       <= s_nxt;
            t       <= t_nxt;
            seq_err <= ~legal;
        end

endmodule

// File: rtl/ga_sequencer.sv
// ga_sequencer: master timing sequencer producing state vector and registered phase strobes
module ga_sequencer
    import ga_pkg::*;
#(
    parameter int READY_T0  = 12,
    parameter int READY_LEN = 4,
    parameter int CCLK_T0   = 4
) (
    input  logic       CLK_n,
    input  logic       RESET,
    output logic [7:0] S,
    output logic [3:0] T,
    output logic       PHI_n,
    output logic       RAS_n,
    output logic       CPU_n,
    output logic       READY,
    output logic       CCLK,
    output logic       VLD0,
    output logic       VLD1,
    output logic       SEQ_ERR
);

    localparam logic [15:0] READY_MASK = win_mask(READY_T0, READY_LEN);
    localparam logic [15:0] CCLK_MASK  = win_mask(CCLK_T0, 8);

    t_idx_t t_nxt;

    ga_johnson_ring u_ring (
        .CLK_n   (CLK_n),
        .RESET   (RESET),
        .s       (S),
        .t       (T),
        .t_nxt   (t_nxt),
        .seq_err (SEQ_ERR)
    );

    // Decode the upcoming index so each output lands aligned with its T
    always_ff @(posedge CLK_n or posedge RESET)
        if (RESET) begin
            PHI_n <= PHI_N_MASK[0];
            RAS_n <= RAS_N_MASK[0];
            CPU_n <= CPU_N_MASK[0];
            READY <= READY_MASK[0];
            CCLK  <= CCLK_MASK[0];
            VLD0  <= 1'b0;
            VLD1  <= 1'b0;
        end else begin
            PHI_n <= PHI_N_MASK[t_nxt];
            RAS_n <= RAS_N_MASK[t_nxt];
            CPU_n <= CPU_N_MASK[t_nxt];
            READY <= READY_MASK[t_nxt];
            CCLK  <= CCLK_MASK[t_nxt];
            VLD0  <= t_nxt == T_VLD0;
            VLD1  <= t_nxt == T_VLD1;
        end

endmodule

// File: tb/tb_ga_sequencer.sv
// tb_ga_sequencer: scoreboard bench for the sequencer, default and wrapped-window instances
module tb_ga_sequencer;

    logic       CLK_n, RESET;
    logic [7:0] s_a, s_b;
    logic [3:0] t_a, t_b;
    logic       phi_a, ras_a, cpu_a, rdy_a, cclk_a, v0_a, v1_a, err_a;
    logic       phi_b, ras_b, cpu_b, rdy_b, cclk_b, v0_b, v1_b, err_b;

    typedef struct packed {
        logic [7:0] s;
        logic [3:0] t;
        logic       phi, ras, cpu, rdy, cclk, v0, v1, err, rdy_b, cclk_b;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   mt = 0;
    logic ill = 1'b0;

    ga_sequencer dut_a (
        .CLK_n(CLK_n), .RESET(RESET), .S(s_a), .T(t_a), .PHI_n(phi_a), .RAS_n(ras_a),
        .CPU_n(cpu_a), .READY(rdy_a), .CCLK(cclk_a), .VLD0(v0_a), .VLD1(v1_a), .SEQ_ERR(err_a)
    );

    ga_sequencer #(.READY_T0(14), .READY_LEN(4), .CCLK_T0(12)) dut_b (
        .CLK_n(CLK_n), .RESET(RESET), .S(s_b), .T(t_b), .PHI_n(phi_b), .RAS_n(ras_b),
        .CPU_n(cpu_b), .READY(rdy_b), .CCLK(cclk_b), .VLD0(v0_b), .VLD1(v1_b), .SEQ_ERR(err_b)
    );

    initial CLK_n = 1'b0;
    always #31 CLK_n = ~CLK_n;

    function automatic logic [7:0] code(input int t);
        logic [7:0] ones;
        ones = 8'hFF;
        return t <= 8 ? 8'((9'd1 << t) - 9'd1) : 8'(ones << (t - 8));
    endfunction

    function automatic exp_t model(input int t, input logic err);
        exp_t e;
        e.s      = code(t);
        e.t      = 4'(t);
        e.phi    = (t % 4) < 2;
        e.ras    = (t % 4) == 0;
        e.cpu    = t < 8;
        e.rdy    = ((t - 12) & 15) < 4;
        e.cclk   = ((t - 4) & 15) < 8;
        e.v0     = t == 3;
        e.v1     = t == 7;
        e.err    = err;
        e.rdy_b  = ((t - 14) & 15) < 4;
        e.cclk_b = ((t - 12) & 15) < 8;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check(input string tag);
        exp_t e;
        if (q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s observed=empty expected=entry", tag);
            return;
        end
        e = q.pop_front();
        chk({tag, ".S"}, s_a, e.s);
        chk({tag, ".T"}, 8'(t_a), 8'(e.t));
        chk({tag, ".PHI_n"}, 8'(phi_a), 8'(e.phi));
        chk({tag, ".RAS_n"}, 8'(ras_a), 8'(e.ras));
        chk({tag, ".CPU_n"}, 8'(cpu_a), 8'(e.cpu));
        chk({tag, ".READY"}, 8'(rdy_a), 8'(e.rdy));
        chk({tag, ".CCLK"}, 8'(cclk_a), 8'(e.cclk));
        chk({tag, ".VLD0"}, 8'(v0_a), 8'(e.v0));
        chk({tag, ".VLD1"}, 8'(v1_a), 8'(e.v1));
        chk({tag, ".SEQ_ERR"}, 8'(err_a), 8'(e.err));
        chk({tag, ".decode13"}, 8'(~s_a[4] & s_a[5]), 8'(e.t == 4'd13));
        chk({tag, ".B.T"}, 8'(t_b), 8'(e.t));
        chk({tag, ".B.READY"}, 8'(rdy_b), 8'(e.rdy_b));
        chk({tag, ".B.CCLK"}, 8'(cclk_b), 8'(e.cclk_b));
    endtask

    task automatic step(input string tag);
        mt = ill ? 0 : (mt + 1) % 16;
        q.push_back(model(mt, ill));
        ill = 1'b0;
        @(posedge CLK_n);
        #1;
        check(tag);
        @(negedge CLK_n);
    endtask

    task automatic reset_now(input string tag);
        RESET = 1'b1;
        mt = 0;
        #1;
        q.push_back(model(0, 1'b0));
        check(tag);
    endtask

    initial begin
        RESET = 1'b1;
        #5;
        q.push_back(model(0, 1'b0));
        check("por");
        @(negedge CLK_n);
        RESET = 1'b0;
        repeat (5) step("warm");
        #5;
        reset_now("rst_mid");
        RESET = 1'b0;
        repeat (17) step("ring");
        repeat (32) step("phase");
        force dut_a.u_ring.s = 8'h5A;
        force dut_b.u_ring.s = 8'h5A;
        #1;
        release dut_a.u_ring.s;
        release dut_b.u_ring.s;
        ill = 1'b1;
        step("illegal");
        step("recover");
        for (int i = 0; i < 16 && mt != 9; i++) step("seek9");
        chk("at_t9", 8'(t_a), 8'd9);
        reset_now("rst_t9");
        for (int i = 0; i < 3; i++) begin
            q.push_back(model(0, 1'b0));
            @(posedge CLK_n);
            #1;
            check("rst_hold");
            @(negedge CLK_n);
        end
        RESET = 1'b0;
        step("release");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
